// File: rtl/branch_predict_bht.sv
// ---------------------------------------------------------------------------
// branch_predict_bht
//
// Direction predictor and mispredict resolver for the 5-stage core.
// A table of 2-bit saturating counters is read in IF to predict the
// direction of a conditional branch. It is trained in EX from the branch
// comparator's actual outcome. In that same EX cycle the block detects a
// misprediction, drives the PC redirect and flushes the two younger
// instructions. It also keeps saturating statistics counters.
//
// Parameters
//   BHT_IDX_W        index width; the table has 2**BHT_IDX_W entries
//   CNT_INIT         counter value loaded at reset (01 = weakly not-taken)
//
// Ports
//   clk              core clock, all state updates on the rising edge
//   rst              asynchronous, active-high reset
//   if_pc            PC of the instruction being fetched
//   if_pred_taken    predicted direction for if_pc (combinational)
//   ex_br_valid      EX holds a conditional branch
//   ex_stall         EX is held this cycle; blocks table and stat updates
//   ex_pc            PC of the branch in EX
//   ex_br_taken      actual branch outcome from the comparator
//   ex_pred_taken    prediction made in IF, piped down with the branch
//   ex_br_target     computed branch target (ex_pc + B-immediate)
//   redirect_valid   misprediction; fetch restarts at redirect_pc
//   redirect_pc      correct next PC
//   flush_if_id      squash the instruction in IF/ID
//   flush_id_ex      squash the instruction in ID/EX
//   stat_branches    count of resolved branches (saturating)
//   stat_mispredicts count of mispredicted branches (saturating)
// ---------------------------------------------------------------------------
module branch_predict_bht #(
  parameter int         BHT_IDX_W = 6,
  parameter logic [1:0] CNT_INIT  = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  input  logic        ex_br_valid,
  input  logic        ex_stall,
  input  logic [31:0] ex_pc,
  input  logic        ex_br_taken,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_br_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int DEPTH = 2 ** BHT_IDX_W;

  // Counter encodings: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  localparam logic [1:0] CNT_MAX = 2'b11;
  localparam logic [1:0] CNT_MIN = 2'b00;

  logic [1:0]           bht [DEPTH];

  logic [BHT_IDX_W-1:0] if_idx;
  logic [BHT_IDX_W-1:0] ex_idx;
  logic [1:0]           ex_cnt;
  logic [1:0]           ex_cnt_next;
  logic                 resolve;
  logic                 mispred;

  // The table is untagged and indexed by word address, so different PCs
  // may share an entry; that aliasing is accepted.
  assign if_idx = if_pc[BHT_IDX_W+1:2];
  assign ex_idx = ex_pc[BHT_IDX_W+1:2];

  // PC bits outside the index carry no information for an untagged table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[31:BHT_IDX_W+2], if_pc[1:0],
                            ex_pc[1:0]};

  // Prediction reads the stored state only. A write to the same entry in
  // this cycle becomes visible next cycle; there is intentionally no bypass.
  assign if_pred_taken = bht[if_idx][1];

  assign resolve = ex_br_valid && !ex_stall;
  assign mispred = resolve && (ex_br_taken != ex_pred_taken);

  assign redirect_valid = mispred;
  assign flush_if_id    = mispred;
  assign flush_id_ex    = mispred;

  // Driven even when no redirect is requested. The fall-through PC wraps
  // naturally at the top of the address space.
  assign redirect_pc = ex_br_taken ? ex_br_target : (ex_pc + 32'd4);

  always_comb begin
    ex_cnt      = bht[ex_idx];
    ex_cnt_next = ex_cnt;
    if (ex_br_taken) begin
      if (ex_cnt != CNT_MAX) ex_cnt_next = ex_cnt + 2'd1;
    end else begin
      if (ex_cnt != CNT_MIN) ex_cnt_next = ex_cnt - 2'd1;
    end
  end

  // Reset reloads every entry at once so a mid-run reset discards any
  // training, including an update that would have landed on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bht[i] <= CNT_INIT;
      end
    end else if (resolve) begin
      bht[ex_idx] <= ex_cnt_next;
    end
  end

  // Statistics stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (resolve) begin
      if (stat_branches != 32'hFFFF_FFFF) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (mispred && (stat_mispredicts != 32'hFFFF_FFFF)) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_bht.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_bht
//
// Directed test of branch_predict_bht with the default parameters
// (64 entries, reset value 01). Inputs change 1 ns after a rising edge and
// outputs are examined 1 ns after that, well away from the next edge.
// All expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_branch_predict_bht;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_br_valid;
  logic        ex_stall;
  logic [31:0] ex_pc;
  logic        ex_br_taken;
  logic        ex_pred_taken;
  logic [31:0] ex_br_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int checks   = 0;
  int failures = 0;

  branch_predict_bht dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .ex_br_valid      (ex_br_valid),
    .ex_stall         (ex_stall),
    .ex_pc            (ex_pc),
    .ex_br_taken      (ex_br_taken),
    .ex_pred_taken    (ex_pred_taken),
    .ex_br_target     (ex_br_target),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush_if_id      (flush_if_id),
    .flush_id_ex      (flush_id_ex),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to 1 ns past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one set of inputs and let the combinational paths settle.
  task automatic applyStimulus(input logic [31:0] ipc, input logic valid,
                               input logic stall, input logic [31:0] epc,
                               input logic taken, input logic pred,
                               input logic [31:0] target);
    if_pc         = ipc;
    ex_br_valid   = valid;
    ex_stall      = stall;
    ex_pc         = epc;
    ex_br_taken   = taken;
    ex_pred_taken = pred;
    ex_br_target  = target;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Redirect and both flushes always move together.
  task automatic checkRedirect(input string tag, input logic expected);
    checkOutput({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, expected});
    checkOutput({tag, ".flush_if_id"},    {31'd0, flush_if_id},    {31'd0, expected});
    checkOutput({tag, ".flush_id_ex"},    {31'd0, flush_id_ex},    {31'd0, expected});
  endtask

  task automatic checkPred(input string tag, input logic expected);
    checkOutput(tag, {31'd0, if_pred_taken}, {31'd0, expected});
  endtask

  task automatic checkStats(input string tag, input int br, input int mp);
    checkOutput({tag, ".stat_branches"},    stat_branches,    br);
    checkOutput({tag, ".stat_mispredicts"}, stat_mispredicts, mp);
  endtask

  initial begin
    $display("[TB] start");
    rst = 1'b1;
    applyStimulus(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checkRedirect("in_reset", 1'b0);
    checkStats("in_reset", 0, 0);
    #2 rst = 1'b0;

    // Post-reset state: index 0 holds 01 -> predict not taken.
    tick();
    applyStimulus(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkPred("reset_pred_0x100", 1'b0);
    checkStats("after_reset", 0, 0);
    checkRedirect("after_reset", 1'b0);

    // Taken branch predicted not-taken: redirect to the target.
    applyStimulus(32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h80);
    checkRedirect("mispred_taken", 1'b1);
    checkOutput("mispred_taken.redirect_pc", redirect_pc, 32'h80);
    tick();
    applyStimulus(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkPred("trained_pred_0x100", 1'b1);
    checkStats("after_first", 1, 1);
    checkRedirect("idle_after_first", 1'b0);

    // Not-taken branch at the top of memory: fall-through wraps to 0.
    applyStimulus(32'hFFFF_FFFC, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h1234);
    checkRedirect("wrap", 1'b1);
    checkOutput("wrap.redirect_pc", redirect_pc, 32'h0000_0000);
    tick();
    applyStimulus(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkPred("wrap_entry_pred", 1'b0);
    checkStats("after_wrap", 2, 2);

    // Stalled resolve and invalid branch must do nothing.
    applyStimulus(32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h500);
    checkRedirect("stalled", 1'b0);
    tick();
    applyStimulus(32'h40, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0, 32'h500);
    checkRedirect("not_valid", 1'b0);
    tick();
    applyStimulus(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkStats("after_suppressed", 2, 2);
    checkPred("suppressed_pred_0x40", 1'b0);

    // Same-cycle read and update of index(0x40): old value this cycle.
    applyStimulus(32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 32'h600);
    checkPred("same_cycle_pre", 1'b0);
    checkOutput("same_cycle.redirect_pc", redirect_pc, 32'h600);
    tick();
    applyStimulus(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkPred("same_cycle_post", 1'b1);
    checkStats("after_same_cycle", 3, 3);

    // Asynchronous reset in the middle of a cycle.
    #2 rst = 1'b1;
    #1;
    checkStats("async_reset", 0, 0);
    checkPred("async_reset_pred_0x40", 1'b0);
    if_pc = 32'h100;
    #1;
    checkPred("async_reset_pred_0x100", 1'b0);
    tick();
    #2 rst = 1'b0;
    tick();

    // Training at 0x200: 01 -> 10 -> 11 -> 11 -> 11, then not-taken -> 10.
    // The prediction seen each cycle is the value before that cycle's update.
    applyStimulus(32'h200, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 32'h300);
    checkPred("train_step1_pre", 1'b0);
    checkRedirect("train_step1", 1'b1);
    tick();
    applyStimulus(32'h200, 1'b1, 1'b0, 32'h200, 1'b1, 1'b1, 32'h300);
    checkPred("train_step2_pre", 1'b1);
    checkRedirect("train_step2", 1'b0);
    tick();
    applyStimulus(32'h200, 1'b1, 1'b0, 32'h200, 1'b1, 1'b1, 32'h300);
    checkPred("train_step3_pre", 1'b1);
    tick();
    applyStimulus(32'h200, 1'b1, 1'b0, 32'h200, 1'b1, 1'b1, 32'h300);
    checkPred("train_step4_pre", 1'b1);
    tick();
    applyStimulus(32'h200, 1'b1, 1'b0, 32'h200, 1'b0, 1'b1, 32'h300);
    checkPred("train_nt_pre", 1'b1);
    checkRedirect("train_nt", 1'b1);
    checkOutput("train_nt.redirect_pc", redirect_pc, 32'h204);
    tick();
    // Counter now 10: still predicts taken; one more not-taken gives 01.
    applyStimulus(32'h200, 1'b1, 1'b0, 32'h200, 1'b0, 1'b1, 32'h300);
    checkPred("after_nt_pred", 1'b1);
    tick();
    applyStimulus(32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkPred("after_second_nt_pred", 1'b0);
    checkStats("final", 6, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
